// File: rtl/operand_regfile.sv
// Operand register file feeding a 16-bit ALU: 2**ADDR_WIDTH registers with
// R0 hard-wired to zero, registered operand capture with write bypass and
// hold, and a registered {N,Z,C,V} status word.
// Ports:
//   clk, rst (sync, active-high)
//   Rd_En, Rd_Addr1, Rd_Addr2, Hold -> ALU_Data_In1, ALU_Data_In2, Op_Valid
//   Wr_En, Wr_Addr, Wr_Data         -> register writeback
//   Flag_En, N, Z, C, V             -> Flags {N,Z,C,V}
module operand_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Rd_En,
  input  logic [ADDR_WIDTH-1:0] Rd_Addr1,
  input  logic [ADDR_WIDTH-1:0] Rd_Addr2,
  input  logic                  Hold,
  output logic [DATA_WIDTH-1:0] ALU_Data_In1,
  output logic [DATA_WIDTH-1:0] ALU_Data_In2,
  output logic                  Op_Valid,
  input  logic                  Wr_En,
  input  logic [ADDR_WIDTH-1:0] Wr_Addr,
  input  logic [DATA_WIDTH-1:0] Wr_Data,
  input  logic                  Flag_En,
  input  logic                  N,
  input  logic                  Z,
  input  logic                  C,
  input  logic                  V,
  output logic [3:0]            Flags
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  logic                  wr_ok;

  assign wr_ok = Wr_En && (Wr_Addr != '0);

  // Same-cycle writeback is forwarded so the operand sees the new value.
  always_comb begin
    rd1 = regs[Rd_Addr1];
    rd2 = regs[Rd_Addr2];
    if (wr_ok && (Wr_Addr == Rd_Addr1)) rd1 = Wr_Data;
    if (wr_ok && (Wr_Addr == Rd_Addr2)) rd2 = Wr_Data;
    if (Rd_Addr1 == '0) rd1 = '0;
    if (Rd_Addr2 == '0) rd2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      ALU_Data_In1 <= '0;
      ALU_Data_In2 <= '0;
      Op_Valid     <= 1'b0;
      Flags        <= 4'b0;
    end else begin
      if (wr_ok) regs[Wr_Addr] <= Wr_Data;
      // Hold freezes the operand stage; a read under hold is dropped.
      if (!Hold) begin
        if (Rd_En) begin
          ALU_Data_In1 <= rd1;
          ALU_Data_In2 <= rd2;
          Op_Valid     <= 1'b1;
        end else begin
          Op_Valid <= 1'b0;
        end
      end
      if (Flag_En) Flags <= {N, Z, C, V};
    end
  end

endmodule

// File: tb/tb_operand_regfile.sv
// Self-checking bench for operand_regfile: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_operand_regfile;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Rd_En = 1'b0;
  logic [AW-1:0] Rd_Addr1 = '0;
  logic [AW-1:0] Rd_Addr2 = '0;
  logic          Hold = 1'b0;
  logic [DW-1:0] ALU_Data_In1;
  logic [DW-1:0] ALU_Data_In2;
  logic          Op_Valid;
  logic          Wr_En = 1'b0;
  logic [AW-1:0] Wr_Addr = '0;
  logic [DW-1:0] Wr_Data = '0;
  logic          Flag_En = 1'b0;
  logic          N = 1'b0;
  logic          Z = 1'b0;
  logic          C = 1'b0;
  logic          V = 1'b0;
  logic [3:0]    Flags;

  int passed = 0;
  int total = 0;

  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_in1;
  logic [DW-1:0] m_in2;
  logic          m_valid;
  logic [3:0]    m_flags;

  operand_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .Rd_En(Rd_En), .Rd_Addr1(Rd_Addr1), .Rd_Addr2(Rd_Addr2),
    .Hold(Hold),
    .ALU_Data_In1(ALU_Data_In1), .ALU_Data_In2(ALU_Data_In2),
    .Op_Valid(Op_Valid),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Flag_En(Flag_En), .N(N), .Z(Z), .C(C), .V(V),
    .Flags(Flags)
  );

  always #5 clk = ~clk;

  // Value an operand should receive: R0 is zero, a same-cycle write wins.
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (Wr_En && Wr_Addr == a) return Wr_Data;
    return m_regs[a];
  endfunction

  task automatic tick();
    logic [DW-1:0] r1, r2;
    r1 = m_read(Rd_Addr1);
    r2 = m_read(Rd_Addr2);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_in1 = '0;
      m_in2 = '0;
      m_valid = 1'b0;
      m_flags = 4'b0;
    end else begin
      if (Wr_En && Wr_Addr != 0) m_regs[Wr_Addr] = Wr_Data;
      if (!Hold) begin
        if (Rd_En) begin
          m_in1 = r1;
          m_in2 = r2;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (Flag_En) m_flags = {N, Z, C, V};
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; Rd_En = 0; Hold = 0; Wr_En = 0; Flag_En = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Wr_En = 1; Wr_Addr = a; Wr_Data = d;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    Rd_En = 1; Rd_Addr1 = a1; Rd_Addr2 = a2;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2, Op_Valid, Flags} !== '0)
      $display("FAIL reset_state: got %h %h %b %b want 0 0 0 0",
               ALU_Data_In1, ALU_Data_In2, Op_Valid, Flags);
    else passed++;
    idle();
  endtask

  task automatic test_basic();
    wr(3, 16'h00AA);
    tick();
    idle();
    rd(3, 0);
    tick();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2, Op_Valid} !== {16'h00AA, 16'h0000, 1'b1})
      $display("FAIL basic_read: got %h %h %b want 00aa 0000 1",
               ALU_Data_In1, ALU_Data_In2, Op_Valid);
    else passed++;
    idle();
    tick();
    total++;
    if ({ALU_Data_In1, Op_Valid} !== {16'h00AA, 1'b0})
      $display("FAIL valid_clear: got %h %b want 00aa 0",
               ALU_Data_In1, Op_Valid);
    else passed++;
  endtask

  task automatic test_bypass();
    wr(5, 16'h1234);
    rd(5, 5);
    tick();
    idle();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2} !== {16'h1234, 16'h1234})
      $display("FAIL bypass_both: got %h %h want 1234 1234",
               ALU_Data_In1, ALU_Data_In2);
    else passed++;
    wr(2, 16'h5555);
    rd(2, 3);
    tick();
    idle();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2} !== {16'h5555, 16'h00AA})
      $display("FAIL bypass_indep: got %h %h want 5555 00aa",
               ALU_Data_In1, ALU_Data_In2);
    else passed++;
    wr(0, 16'hFFFF);
    rd(0, 0);
    tick();
    idle();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2} !== 32'h0)
      $display("FAIL r0_bypass: got %h %h want 0000 0000",
               ALU_Data_In1, ALU_Data_In2);
    else passed++;
    rd(0, 5);
    tick();
    idle();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2} !== {16'h0000, 16'h1234})
      $display("FAIL r0_read: got %h %h want 0000 1234",
               ALU_Data_In1, ALU_Data_In2);
    else passed++;
  endtask

  task automatic test_hold();
    wr(1, 16'h0011);
    tick();
    wr(2, 16'h0022);
    tick();
    idle();
    rd(1, 2);
    tick();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2} !== {16'h0011, 16'h0022})
      $display("FAIL hold_capture: got %h %h want 0011 0022",
               ALU_Data_In1, ALU_Data_In2);
    else passed++;
    Hold = 1;
    rd(4, 4);
    wr(1, 16'h9999);
    for (int i = 0; i < 3; i++) begin
      tick();
      Wr_En = 0;
      total++;
      if ({ALU_Data_In1, ALU_Data_In2, Op_Valid} !==
          {16'h0011, 16'h0022, 1'b1})
        $display("FAIL hold_cycle%0d: got %h %h %b want 0011 0022 1",
                 i, ALU_Data_In1, ALU_Data_In2, Op_Valid);
      else passed++;
    end
    idle();
    rd(1, 1);
    tick();
    idle();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2} !== {16'h9999, 16'h9999})
      $display("FAIL hold_write: got %h %h want 9999 9999",
               ALU_Data_In1, ALU_Data_In2);
    else passed++;
  endtask

  task automatic test_flags();
    Flag_En = 1; N = 1; Z = 0; C = 1; V = 0;
    tick();
    total++;
    if (Flags !== 4'b1010)
      $display("FAIL flags_load: got %b want 1010", Flags);
    else passed++;
    Flag_En = 0; N = 1; Z = 1; C = 1; V = 1;
    tick();
    total++;
    if (Flags !== 4'b1010)
      $display("FAIL flags_hold: got %b want 1010", Flags);
    else passed++;
  endtask

  task automatic test_reset_mid();
    wr(7, 16'hBEEF);
    tick();
    idle();
    rd(7, 7);
    tick();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2} !== {16'hBEEF, 16'hBEEF})
      $display("FAIL r7_capture: got %h %h want beef beef",
               ALU_Data_In1, ALU_Data_In2);
    else passed++;
    Hold = 1;
    tick();
    rst = 1;
    wr(6, 16'h1111);
    Flag_En = 1;
    tick();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2, Op_Valid, Flags} !== '0)
      $display("FAIL mid_reset: got %h %h %b %b want 0 0 0 0",
               ALU_Data_In1, ALU_Data_In2, Op_Valid, Flags);
    else passed++;
    idle();
    rd(7, 6);
    tick();
    idle();
    total++;
    if ({ALU_Data_In1, ALU_Data_In2, Op_Valid} !== {32'h0, 1'b1})
      $display("FAIL post_reset_read: got %h %h %b want 0000 0000 1",
               ALU_Data_In1, ALU_Data_In2, Op_Valid);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      Hold = ($urandom_range(0, 3) == 0);
      Rd_En = $urandom_range(0, 1);
      Rd_Addr1 = AW'($urandom);
      Rd_Addr2 = ($urandom_range(0, 3) == 0) ? Rd_Addr1 : AW'($urandom);
      Wr_En = $urandom_range(0, 1);
      Wr_Addr = ($urandom_range(0, 2) == 0) ? Rd_Addr1 : AW'($urandom);
      Wr_Data = DW'($urandom);
      Flag_En = $urandom_range(0, 1);
      {N, Z, C, V} = 4'($urandom);
      tick();
      total++;
      if ({ALU_Data_In1, ALU_Data_In2, Op_Valid, Flags} !==
          {m_in1, m_in2, m_valid, m_flags})
        $display("FAIL random%0d: got %h %h %b %b want %h %h %b %b", i,
                 ALU_Data_In1, ALU_Data_In2, Op_Valid, Flags,
                 m_in1, m_in2, m_valid, m_flags);
      else passed++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_hold();
    test_flags();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
